// File: rtl/four_to_one_multiplexer.sv
// Registered 4-to-1 word selector: {S1,S0} picks A0..A3, the choice lands on Y one clock later.
// sel_q and valid travel with Y so downstream logic knows which operand it holds and when it is fresh.
module four_to_one_multiplexer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] A3,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] Y,
  output logic [1:0]       sel_q,
  output logic             valid
);

  logic [1:0]       idx;
  logic [WIDTH-1:0] a_arr [4];
  logic [WIDTH-1:0] mux_d;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic [1:0]       sel_d;
  logic             valid_d;
  logic             valid_q;

  assign idx = {S1, S0};

  // Plain array index: an X/Z select reads back X in a four-state simulator instead of picking a word.
  always_comb begin
    a_arr[0] = A0;
    a_arr[1] = A1;
    a_arr[2] = A2;
    a_arr[3] = A3;
    mux_d    = a_arr[idx];
  end

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (en) begin
      y_d     = mux_d;
      sel_d   = idx;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  assign Y     = y_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_four_to_one_multiplexer.sv
// Bench for four_to_one_multiplexer: directed scenarios plus random traffic, every cycle checked
// against a word-array model of the selector.
module tb_four_to_one_multiplexer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] A0, A1, A2, A3;
  logic             S0, S1;
  logic [WIDTH-1:0] Y;
  logic [1:0]       sel_q;
  logic             valid;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  int exp_y;
  int exp_sel;
  int exp_v;

  four_to_one_multiplexer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A0   (A0),
    .A1   (A1),
    .A2   (A2),
    .A3   (A3),
    .S0   (S0),
    .S1   (S1),
    .Y    (Y),
    .sel_q(sel_q),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Model: after an accepted edge Y is the word whose number is 2*S1+S0.
  task automatic tick();
    int words [4];
    @(posedge clk);
    if (rst_n) begin
      if (en) begin
        words[0] = int'(A0);
        words[1] = int'(A1);
        words[2] = int'(A2);
        words[3] = int'(A3);
        exp_sel  = 2 * int'(S1) + int'(S0);
        exp_y    = words[exp_sel];
        exp_v    = 1;
      end else begin
        exp_v = 0;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_y   = 0;
    exp_sel = 0;
    exp_v   = 0;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_y", int'(Y), exp_y);
      check("model_sel", int'(sel_q), exp_sel);
      check("model_valid", int'(valid), exp_v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit_static [4];
    int lit_sweep [4];
    lit_static = '{14, 8, 4, 9};
    lit_sweep  = '{14, 4, 8, 9};

    rst_n = 1'b1;
    en = 1'b1;
    A0 = 8'd14; A1 = 8'd8; A2 = 8'd4; A3 = 8'd9;
    S1 = 1'b1; S0 = 1'b1;

    // Reset falls between clock edges; outputs must clear before any edge arrives.
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_y", int'(Y), 0);
    check("reset_sel", int'(sel_q), 0);
    check("reset_valid", int'(valid), 0);
    chk_on = 1'b1;
    tick();
    tick();
    check("reset_hold_y", int'(Y), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {S1, S0} = 2'(i);
      tick();
      check("static_y", int'(Y), lit_static[i]);
      check("static_sel", int'(sel_q), i);
      check("static_valid", int'(valid), 1);
    end

    // {S0,S1} counts, so S0 is the MSB of the counter.
    for (int c = 0; c < 8; c++) begin
      S0 = c[1];
      S1 = c[0];
      tick();
      check("sweep_y", int'(Y), lit_sweep[c % 4]);
    end

    {S1, S0} = 2'b11;
    tick();
    check("hold_cap_y", int'(Y), 9);
    en = 1'b0;
    {S1, S0} = 2'b00;
    A0 = 8'd77; A3 = 8'd55;
    tick();
    check("hold_y", int'(Y), 9);
    check("hold_sel", int'(sel_q), 3);
    check("hold_valid", int'(valid), 0);
    {S1, S0} = 2'b10;
    tick();
    check("hold2_y", int'(Y), 9);
    A0 = 8'd14; A3 = 8'd9;

    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      {S1, S0} = 2'(c);
      tick();
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_y", int'(Y), 0);
    check("midrst_valid", int'(valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    {S1, S0} = 2'b01;
    tick();
    check("postrst_y", int'(Y), 8);
    check("postrst_sel", int'(sel_q), 1);
    check("postrst_valid", int'(valid), 1);

    A1 = 8'hFF; A2 = 8'h00;
    for (int c = 0; c < 8; c++) begin
      {S1, S0} = (c % 2 == 0) ? 2'b01 : 2'b10;
      tick();
      check("corner_y", int'(Y), (c % 2 == 0) ? 32'hFF : 32'h00);
    end

    for (int c = 0; c < 400; c++) begin
      A0 = 8'($urandom);
      A1 = 8'($urandom);
      A2 = 8'($urandom);
      A3 = 8'($urandom);
      S0 = 1'($urandom);
      S1 = 1'($urandom);
      en = ($urandom_range(0, 3) != 0);
      tick();
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
